// File: rtl/mul8_seq_ctrl.sv
// Sequencer for an unsigned 8x8 -> 16-bit multiply built from one shared 4x4
// multiplier: four nibble-pair products are accumulated over four cycles.
module mul8_seq_ctrl #(
    parameter int HALF_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*HALF_W-1:0]   a,
    input  logic [2*HALF_W-1:0]   b,
    output logic [HALF_W-1:0]     mul_m,
    output logic [HALF_W-1:0]     mul_q,
    input  logic [2*HALF_W-1:0]   mul_p,
    output logic                  busy,
    output logic                  done,
    output logic [4*HALF_W-1:0]   product
);

    localparam int W  = 2 * HALF_W;
    localparam int PW = 2 * W;

    typedef enum logic [2:0] {
        IDLE,
        PP0,
        PP1,
        PP2,
        PP3
    } state_t;

    state_t          state;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   p_ext;

    assign p_ext = {{(PW-W){1'b0}}, mul_p};
    assign busy  = (state != IDLE);

    // Operands are captured at acceptance so input changes mid-operation are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc   <= '0;
                        state <= PP0;
                    end
                end
                PP0: begin
                    acc   <= acc + p_ext;
                    state <= PP1;
                end
                PP1: begin
                    acc   <= acc + (p_ext << HALF_W);
                    state <= PP2;
                end
                PP2: begin
                    acc   <= acc + (p_ext << HALF_W);
                    state <= PP3;
                end
                PP3: begin
                    product <= acc + (p_ext << W);
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mul_m = '0;
        mul_q = '0;
        case (state)
            PP0: begin
                mul_m = a_r[HALF_W-1:0];
                mul_q = b_r[HALF_W-1:0];
            end
            PP1: begin
                mul_m = a_r[W-1:HALF_W];
                mul_q = b_r[HALF_W-1:0];
            end
            PP2: begin
                mul_m = a_r[HALF_W-1:0];
                mul_q = b_r[W-1:HALF_W];
            end
            PP3: begin
                mul_m = a_r[W-1:HALF_W];
                mul_q = b_r[W-1:HALF_W];
            end
            default: begin
                mul_m = '0;
                mul_q = '0;
            end
        endcase
    end

endmodule
